mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
REQ-004 ctrl_MULT  input  1  single-cycle start pulse for signed multiply.
REQ-005 ctrl_DIV  input  1  single-cycle start pulse for signed divide.
REQ-006 data_operandA  input  32  multiplicand or dividend, two's complement, sampled on the start edge.
REQ-007 data_operandB  input  32  multiplier or divisor, two's complement, sampled on the start edge.
REQ-008 data_result  output  32  product (low 32 bits) or quotient.
REQ-009 data_exception  output  1  overflow or divide-by-zero flag, valid while data_resultRDY=1.
REQ-010 data_resultRDY  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high from the cycle after a start edge until data_resultRDY deasserts.

Function
REQ-012 States SHALL be IDLE, MUL_RUN, DIV_RUN, DONE; a start edge is an edge with reset=0 and ctrl_MULT or ctrl_DIV high.
REQ-013 IDLE: ctrl_MULT -> MUL_RUN; else ctrl_DIV -> DIV_RUN; operands latched, iteration counter cleared to 0.
REQ-014 Simultaneous ctrl_MULT and ctrl_DIV SHALL start a multiply; ctrl_DIV is ignored.
REQ-015 Multiply SHALL be radix-2 Booth, one iteration per edge, 32 iterations, 65-bit product register.
REQ-016 Divide SHALL be restoring division on operand magnitudes, one quotient bit per edge, 32 iterations; quotient sign = signA XOR signB; truncation toward zero; remainder discarded.
REQ-017 Counter SHALL be 6 bits; transition to DONE on the edge that completes iteration 31 (counter = 31 -> DONE).
REQ-018 Latency: with start at edge E0, iterations occur on E1..E32; data_resultRDY SHALL be 1 only in the cycle between E32 and E33; DONE -> IDLE at E33 unconditionally.
REQ-019 data_result and data_exception SHALL hold their DONE-cycle values after return to IDLE until the next start edge or reset.
REQ-020 Multiply exception SHALL be 1 iff the 64-bit signed product is outside [-2^31, 2^31-1]; data_result = low 32 bits regardless.
REQ-021 Divisor = 0: data_exception=1, data_result=0x00000000, same latency as REQ-018.
REQ-022 0x80000000 / 0xFFFFFFFF: data_exception=1, data_result=0x80000000.
REQ-023 A start pulse while in MUL_RUN, DIV_RUN or DONE SHALL abort the current operation without any data_resultRDY pulse, latch new operands, and restart per REQ-013/REQ-014; E0 becomes that edge.
REQ-024 busy SHALL equal 1 in MUL_RUN, DIV_RUN and DONE, 0 in IDLE.

Reset
REQ-025 reset=1 on an edge SHALL force IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0, clearing all internal registers.
REQ-026 reset SHALL take priority over any simultaneous ctrl_MULT/ctrl_DIV; an operation in progress SHALL be discarded with no data_resultRDY pulse.
REQ-027 Outputs SHALL be undefined-free (known 0) from the first edge with reset=1.

Verification
REQ-028 MULT A=7, B=-3 -> data_resultRDY exactly 32 edges after start; data_result=0xFFFFFFEB, exception=0.
REQ-029 MULT A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1; A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF, exception=0.
REQ-030 DIV A=-7, B=2 -> data_result=0xFFFFFFFD (-3), exception=0; DIV A=100, B=0 -> data_result=0, exception=1 at same latency.
REQ-031 DIV A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, exception=1.
REQ-032 MULT 5*5 started, DIV 9/3 pulsed 10 edges later -> no ready pulse for multiply; single ready pulse 32 edges after DIV pulse with data_result=3.
REQ-033 reset asserted 15 edges into MULT 6*6 -> all outputs 0 next cycle, no data_resultRDY pulse for 40 edges; simultaneous ctrl_MULT+ctrl_DIV with A=6, B=3 -> data_result=18.

Source files
------------

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative signed 32x32 multiplier (radix-2 Booth, 65-bit
//                product register) and signed 32/32 divider (restoring
//                division on magnitudes). One iteration per clock edge and
//                32 iterations per operation. Results are held until the
//                next start edge or reset.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [5:0]  LAST_ITER = 6'd31;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE   = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q,   cnt_d;
  logic [31:0] a_q,     a_d;     // operand A as latched (signed)
  logic [31:0] b_q,     b_d;     // operand B as latched (signed)
  logic [64:0] prod_q,  prod_d;  // Booth register {upper, multiplier, q(-1)}
  logic [31:0] rem_q,   rem_d;   // partial remainder
  logic [31:0] quo_q,   quo_d;   // dividend magnitude shifting out, quotient in
  logic [31:0] dvs_q,   dvs_d;   // divisor magnitude
  logic [31:0] res_q,   res_d;
  logic        exc_q,   exc_d;

  logic        w_start;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_booth_sum;
  logic [64:0] w_prod_step;
  logic        w_mul_ovf;
  logic [32:0] w_rem_shift;
  logic [32:0] w_rem_diff;
  logic [31:0] w_rem_step;
  logic [31:0] w_quo_step;
  logic [31:0] w_quo_signed;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_abs_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign w_abs_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

  // One Booth step. The add is done at 33 bits so that subtracting INT_MIN
  // cannot wrap; the extra bit becomes the sign shifted into the register.
  always_comb begin
    w_booth_sum = {prod_q[64], prod_q[64:33]};
    case (prod_q[1:0])
      2'b01:   w_booth_sum = {prod_q[64], prod_q[64:33]} + {a_q[31], a_q};
      2'b10:   w_booth_sum = {prod_q[64], prod_q[64:33]} - {a_q[31], a_q};
      default: w_booth_sum = {prod_q[64], prod_q[64:33]};
    endcase
    w_prod_step = {w_booth_sum, prod_q[32:1]};
    // 64-bit product is w_prod_step[64:1]; it fits in 32 signed bits only
    // when bits 63..31 are all equal.
    w_mul_ovf   = ~((&w_prod_step[64:32]) | ~(|w_prod_step[64:32]));
  end

  // One restoring-division step: shift in the next dividend bit and keep the
  // trial difference only when it did not go negative.
  always_comb begin
    w_rem_shift = {rem_q, quo_q[31]};
    w_rem_diff  = w_rem_shift - {1'b0, dvs_q};
    if (w_rem_diff[32]) begin
      w_rem_step = w_rem_shift[31:0];
      w_quo_step = {quo_q[30:0], 1'b0};
    end else begin
      w_rem_step = w_rem_diff[31:0];
      w_quo_step = {quo_q[30:0], 1'b1};
    end
    w_quo_signed = (a_q[31] ^ b_q[31]) ? (~w_quo_step + 32'd1) : w_quo_step;
  end

  // Next-state and datapath update; a start pulse restarts from any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    exc_d   = exc_q;

    if (w_start) begin
      state_d = ctrl_MULT ? MUL_RUN : DIV_RUN;
      cnt_d   = 6'd0;
      a_d     = data_operandA;
      b_d     = data_operandB;
      prod_d  = {32'd0, data_operandB, 1'b0};
      rem_d   = 32'd0;
      quo_d   = w_abs_a;
      dvs_d   = w_abs_b;
    end else begin
      case (state_q)
        MUL_RUN: begin
          prod_d = w_prod_step;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) begin
            state_d = DONE;
            res_d   = w_prod_step[32:1];
            exc_d   = w_mul_ovf;
          end
        end
        DIV_RUN: begin
          rem_d = w_rem_step;
          quo_d = w_quo_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) begin
            state_d = DONE;
            if (b_q == 32'd0) begin
              res_d = 32'd0;
              exc_d = 1'b1;
            end else if ((a_q == INT_MIN) && (b_q == NEG_ONE)) begin
              res_d = INT_MIN;
              exc_d = 1'b1;
            end else begin
              res_d = w_quo_signed;
              exc_d = 1'b0;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      prod_q  <= 65'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      res_q   <= 32'd0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Scoreboard bench for mult_div_unit. Stimulus pushes the
//                hand-computed result, exception and completion cycle; a
//                negedge monitor pops and compares on every ready pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   rdy_count   = 0;

  mult_div_unit dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count rising edges; a start driven before edge N has E0 = N.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every ready pulse against the oldest expectation and
  // flag pulses nobody expected or expectations whose cycle has passed.
  always @(negedge clock) begin
    if (data_resultRDY !== 1'b0) begin
      rdy_count++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rdy: got rdy=%b expected no pulse (cycle %0d)", data_resultRDY, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",    data_result,         e.res);
        check("exception", {31'd0, data_exception}, {31'd0, e.exc});
        check("latency",   cyc,                 e.cyc);
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_rdy: got no pulse expected one at cycle %0d (now %0d)", sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
  end

  task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ee);
    exp_t e;
    @(posedge clock); #1;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    e.res = er;
    e.exc = ee;
    e.cyc = cyc + 1 + 32;
    sb.push_back(e);
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    check("busy_running", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input logic [31:0] er, input logic ee);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clock);
    #1;
    check("busy_idle",   {31'd0, busy},           32'd0);
    check("rdy_idle",    {31'd0, data_resultRDY}, 32'd0);
    check("result_held", data_result,             er);
    check("exc_held",    {31'd0, data_exception}, {31'd0, ee});
  endtask

  task automatic run_op(input logic m, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee);
    start_op(m, ~m, a, b, er, ee);
    wait_done(er, ee);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_before;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result,             32'd0);
    check("reset_exc",    {31'd0, data_exception}, 32'd0);
    check("reset_rdy",    {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy",   {31'd0, busy},           32'd0);
    reset = 1'b0;

    // Multiplies
    run_op(1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op(1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
    run_op(1'b1, 32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFA,  32'hFFFF_FFF9, 32'h0000_002A, 1'b0);
    run_op(1'b1, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1);
    run_op(1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
    run_op(1'b1, 32'hFFFF_8000,  32'h0001_0000, 32'h8000_0000, 1'b0);
    run_op(1'b1, 32'h0000_8000,  32'h0001_0000, 32'h8000_0000, 1'b1);

    // Divides
    run_op(1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
    run_op(1'b0, 32'd100,        32'd0,         32'h0000_0000, 1'b1);
    run_op(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op(1'b0, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0);
    run_op(1'b0, 32'd7,          32'hFFFF_FF9C, 32'h0000_0000, 1'b0);

    // Abort: multiply 5*5 replaced by divide 9/3 ten edges later
    start_op(1'b1, 1'b0, 32'd5, 32'd5, 32'd25, 1'b0);
    repeat (8) @(posedge clock);
    #1;
    void'(sb.pop_back());
    start_op(1'b0, 1'b1, 32'd9, 32'd3, 32'd3, 1'b0);
    wait_done(32'd3, 1'b0);

    // Reset in the middle of multiply 6*6
    start_op(1'b1, 1'b0, 32'd6, 32'd6, 32'd36, 1'b0);
    repeat (13) @(posedge clock);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midreset_result", data_result,             32'd0);
    check("midreset_exc",    {31'd0, data_exception}, 32'd0);
    check("midreset_rdy",    {31'd0, data_resultRDY}, 32'd0);
    check("midreset_busy",   {31'd0, busy},           32'd0);
    rdy_before = rdy_count;
    repeat (40) @(posedge clock);
    #1;
    check("no_rdy_after_reset", rdy_count, rdy_before);

    // Simultaneous start pulses: multiply wins
    start_op(1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);
    wait_done(32'd18, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
